// File: rtl/cardio_pkg.sv
// rtl/cardio_pkg.sv - shared widths and state encoding for the Cardio feature loader
package cardio_pkg;

  localparam int NUM_FEAT = 21;
  localparam int FEAT_W   = 4;
  localparam int CLS_W    = 2;
  localparam int PRED_W   = 63;

  localparam int CNT_W    = $clog2(NUM_FEAT);
  localparam int INP_W    = NUM_FEAT * FEAT_W;
  localparam int SET_W    = 4;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/cardio_feature_loader.sv
// rtl/cardio_feature_loader.sv - streams 21 features into the MLP input bus and returns its result
module cardio_feature_loader
  import cardio_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_feat,
  input  logic              s_last,
  output logic [INP_W-1:0]  cls_inp,
  input  logic [CLS_W-1:0]  cls_out,
  input  logic [PRED_W-1:0] cls_predo,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CLS_W-1:0]  m_class,
  output logic [PRED_W-1:0] m_scores,
  output logic              err
);

  localparam logic [SET_W-1:0] SETTLE_LIM = SET_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_FEAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              accept;

  // Features are only taken while loading; the classifier input is frozen otherwise.
  assign s_ready = (state == LOAD);
  assign accept  = s_valid && s_ready;

  // Frame assembly, settle wait and result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      settle_cnt <= '0;
      cls_inp    <= '0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      m_scores   <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
              if (cnt == CNT_W'(k)) begin
                cls_inp[k*FEAT_W +: FEAT_W] <= s_feat;
              end
            end
            if (cnt == LAST_IDX && s_last) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end else if (cnt == LAST_IDX || s_last) begin
              // Short or overlong frame: drop it, stale slots get overwritten next frame.
              err <= 1'b1;
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
          if (settle_cnt + SET_W'(1) == SETTLE_LIM) begin
            m_class  <= cls_out;
            m_scores <= cls_predo;
            m_valid  <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            state   <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
